row_request_encoder: RTL and testbench

//   Encoder-side counterpart of the 3-to-8 row address decoder. It takes eight per-row access

---
 rtl/row_enc_pkg.sv | 38 +++
 rtl/rr_arbiter8.sv | 25 ++
 rtl/row_request_encoder.sv | 157 +++++++++++++++
 tb/tb_row_request_encoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/row_enc_pkg.sv
// ----------------------------------------------------------------------------
// row_enc_pkg
//   Shared definitions for the row request encoder.
//   Contents:
//     ADR_W, N_ROWS    address width and row count of the 3-to-8 decoder
//     row_enc_state_t  window FSM states (IDLE, ARB, SEL, GAP)
//     rr_pick()        round-robin pick; returns {found, idx}
// ----------------------------------------------------------------------------
package row_enc_pkg;

    localparam int ADR_W  = 3;
    localparam int N_ROWS = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        SEL,
        GAP
    } row_enc_state_t;

    // The search starts at ptr+1 and wraps modulo 8. The loop walks from the
    // lowest-priority offset (ptr itself) up to the highest (ptr+1), so the
    // last hit written is the winner. The 3-bit add provides the wrap.
    function automatic logic [ADR_W:0] rr_pick(input logic [N_ROWS-1:0] req,
                                               input logic [ADR_W-1:0]  ptr);
        logic [ADR_W:0]   res;
        logic [ADR_W-1:0] idx;
        res = '0;
        for (int k = N_ROWS; k >= 1; k--) begin
            idx = ptr + ADR_W'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// ----------------------------------------------------------------------------
// rr_arbiter8
//   Combinational 8-way round-robin arbiter.
//   Ports:
//     req_x   in   8  request per row
//     rr_ptr  in   3  last granted row; search starts one above it
//     winner  out  3  index of the chosen row (valid when found=1)
//     found   out  1  at least one request was set
// ----------------------------------------------------------------------------
module rr_arbiter8
    import row_enc_pkg::*;
(
    input  logic [N_ROWS-1:0] req_x,
    input  logic [ADR_W-1:0]  rr_ptr,
    output logic [ADR_W-1:0]  winner,
    output logic              found
);

    logic [ADR_W:0] pick;

    assign pick   = rr_pick(req_x, rr_ptr);
    assign found  = pick[ADR_W];
    assign winner = pick[ADR_W-1:0];

endmodule

// File: rtl/row_request_encoder.sv
// ----------------------------------------------------------------------------
// row_request_encoder
//   Picks one of eight row requests round-robin and drives the 3-to-8 row
//   decoder (adr2..0 + select) for one access window. The window ends on
//   access_done from the bitcell array or on a timeout.
//   Parameters:
//     GAP_CYC      idle cycles spent in GAP after a window (0..7)
//     TIMEOUT_CYC  max cycles select is held without access_done (1..255)
//   Ports:
//     clk           in   1  clock, rising edge
//     rst_n         in   1  asynchronous active-low reset
//     req_x         in   8  level request per row
//     access_done   in   1  access of the selected row complete (pulse)
//     adr0/1/2      out  1  registered row address to the decoder
//     select        out  1  registered decoder enable, high only in SEL
//     grant_x       out  8  one-hot grant pulse on completion
//     timeout_err   out  1  sticky, set when a window times out
//   Optional feature, macro ROW_ENC_LOOPBACK_CHECK_EN:
//     sel_x_fb      in   8  decoder output fed back
//     loopback_err  out  1  sticky, set when sel_x_fb disagrees with the
//                           selected row (SEL from its 2nd cycle) or is
//                           non-zero in IDLE/GAP
// ----------------------------------------------------------------------------
module row_request_encoder
    import row_enc_pkg::*;
#(
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_ROWS-1:0] req_x,
    input  logic              access_done,
    output logic              adr0,
    output logic              adr1,
    output logic              adr2,
    output logic              select,
    output logic [N_ROWS-1:0] grant_x,
    output logic              timeout_err
`ifdef ROW_ENC_LOOPBACK_CHECK_EN
    ,
    input  logic [N_ROWS-1:0] sel_x_fb,
    output logic              loopback_err
`endif
);

    // With GAP_CYC=0 a finished window returns straight to IDLE.
    localparam row_enc_state_t POST_SEL = (GAP_CYC == 0) ? IDLE : GAP;

    row_enc_state_t    state;
    logic [ADR_W-1:0]  rr_ptr;
    logic [ADR_W-1:0]  adr;
    logic [7:0]        wait_cnt;
    logic [2:0]        gap_cnt;
    logic [ADR_W-1:0]  arb_winner;
    logic              arb_found;
    logic [N_ROWS-1:0] adr_onehot;

    rr_arbiter8 u_arb (
        .req_x  (req_x),
        .rr_ptr (rr_ptr),
        .winner (arb_winner),
        .found  (arb_found)
    );

    // adr holds the latched winner from ARB until the next ARB.
    assign adr0       = adr[0];
    assign adr1       = adr[1];
    assign adr2       = adr[2];
    assign adr_onehot = {{(N_ROWS-1){1'b0}}, 1'b1} << adr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= 3'd7;
            adr         <= '0;
            select      <= 1'b0;
            grant_x     <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
        end else begin
            grant_x <= '0;
            case (state)
                IDLE: begin
                    if (req_x != '0) begin
                        state <= ARB;
                    end
                end
                // The request may have been withdrawn since IDLE saw it.
                ARB: begin
                    if (arb_found) begin
                        adr      <= arb_winner;
                        select   <= 1'b1;
                        wait_cnt <= '0;
                        state    <= SEL;
                    end else begin
                        state <= IDLE;
                    end
                end
                // Done has priority over a timeout landing on the same edge.
                // Either way the pointer advances so a dead row cannot
                // starve the others.
                SEL: begin
                    if (access_done) begin
                        grant_x <= adr_onehot;
                        rr_ptr  <= adr;
                        select  <= 1'b0;
                        gap_cnt <= '0;
                        state   <= POST_SEL;
                    end else if (wait_cnt == 8'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= adr;
                        select      <= 1'b0;
                        gap_cnt     <= '0;
                        state       <= POST_SEL;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 3'(GAP_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROW_ENC_LOOPBACK_CHECK_EN
    // The first SEL cycle is skipped because the decoder output is still
    // settling from select rising; ARB is unchecked for the same reason.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loopback_err <= 1'b0;
        end else begin
            case (state)
                SEL: begin
                    if (wait_cnt != '0 && sel_x_fb != adr_onehot) begin
                        loopback_err <= 1'b1;
                    end
                end
                IDLE, GAP: begin
                    if (sel_x_fb != '0) begin
                        loopback_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_row_request_encoder.sv
// ----------------------------------------------------------------------------
// tb_row_request_encoder
//   Self-checking bench for row_request_encoder (default parameters).
//   Directed scenarios plus randomized transactions are compared against a
//   transaction-level model: a round-robin pointer, a modulo-8 search, and
//   the done/timeout rule for how long select stays high.
// ----------------------------------------------------------------------------
module tb_row_request_encoder;

    localparam int GAP_CYC     = 1;
    localparam int TIMEOUT_CYC = 15;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_x;
    logic       access_done;
    logic       adr0, adr1, adr2, select;
    logic [7:0] grant_x;
    logic       timeout_err;
    logic [2:0] adr_bus;

    int checks = 0;
    int errors = 0;
    int model_ptr = 7;
    bit model_err = 0;

`ifdef ROW_ENC_LOOPBACK_CHECK_EN
    logic [7:0] sel_x_fb;
    logic       loopback_err;
    bit         fb_force = 0;
    logic [7:0] fb_value = '0;

    // Ideal decoder model feeding back onto sel_x_fb unless a fault is forced.
    always_comb begin
        sel_x_fb = select ? (8'd1 << adr_bus) : 8'd0;
        if (fb_force) sel_x_fb = fb_value;
    end
`endif

    assign adr_bus = {adr2, adr1, adr0};

    row_request_encoder #(
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_x        (req_x),
        .access_done  (access_done),
        .adr0         (adr0),
        .adr1         (adr1),
        .adr2         (adr2),
        .select       (select),
        .grant_x      (grant_x),
        .timeout_err  (timeout_err)
`ifdef ROW_ENC_LOOPBACK_CHECK_EN
        ,
        .sel_x_fb     (sel_x_fb),
        .loopback_err (loopback_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global safety net: every wait below is bounded, this only guards bugs
    // in the bench itself.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First requesting row above ptr, wrapping modulo 8.
    function automatic int pickModel(input logic [7:0] req, input int ptr);
        for (int k = 1; k <= 8; k++) begin
            int idx;
            idx = (ptr + k) % 8;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic doReset();
        rst_n = 1'b0;
        req_x = '0;
        access_done = 1'b0;
        #3;
        checkOutput("rstSelect", 32'(select), 0);
        checkOutput("rstGrant", 32'(grant_x), 0);
        checkOutput("rstAdr", 32'(adr_bus), 0);
        checkOutput("rstTimeout", 32'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 7;
        model_err = 0;
    endtask

    // Requests idle; optionally pulses access_done at random, which must be
    // ignored outside SEL.
    task automatic idleCycles(input int cycles, input bit random_done);
        req_x = '0;
        for (int c = 0; c < cycles; c++) begin
            access_done = random_done ? 1'($urandom % 2) : 1'b0;
            @(negedge clk);
            access_done = 1'b0;
            checkOutput("idleSelect", 32'(select), 0);
            checkOutput("idleGrant", 32'(grant_x), 0);
        end
    endtask

    // One access window. done_at: SEL cycle (1-based) on which access_done
    // is driven; outside 1..TIMEOUT_CYC means the window times out.
    // exp_lat: negedges from the call until select is seen high.
    task automatic applyStimulus(input logic [7:0] req, input int done_at,
                                 input int exp_lat, input bit scramble);
        int  lat;
        int  n;
        int  win;
        bit  exp_to;
        req_x = req;
        win = pickModel(req, model_ptr);
        lat = 0;
        while (!select && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("adr", 32'(adr_bus), 32'(win));
        n = 0;
        while (select && n < 40) begin
            checkOutput("adrHold", 32'(adr_bus), 32'(win));
            checkOutput("grantInSel", 32'(grant_x), 0);
            n++;
            access_done = (n == done_at);
            if (scramble) req_x = 8'($urandom);
            @(negedge clk);
            access_done = 1'b0;
        end
        exp_to = !(done_at >= 1 && done_at <= TIMEOUT_CYC);
        checkOutput("selHighCycles", 32'(n), exp_to ? 32'(TIMEOUT_CYC) : 32'(done_at));
        checkOutput("grant", 32'(grant_x), exp_to ? 32'd0 : (32'd1 << win));
        model_err = model_err | exp_to;
        checkOutput("timeoutErr", 32'(timeout_err), 32'(model_err));
        model_ptr = win;
    endtask

    initial begin
        rst_n = 1'b0;
        req_x = '0;
        access_done = 1'b0;
        @(negedge clk);

        // Reset state, then quiet for 20 cycles.
        doReset();
        idleCycles(20, 0);

        // 0x81 from pointer 7: row 0, then (held) row 7.
        applyStimulus(8'h81, 2, 2, 0);
        applyStimulus(8'h81, 3, GAP_CYC + 2, 0);
        idleCycles(4, 0);

        // Single row 4: adr=100, done two cycles after select rises.
        applyStimulus(8'h10, 2, 2, 0);
        idleCycles(4, 0);

        // All rows held: 0..7, 0..7 after reset, varied done delay.
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'hFF, 1 + (i % 3), (i == 0) ? 2 : GAP_CYC + 2, 0);
        end
        idleCycles(4, 0);

        // Done on the timeout edge wins; then a real timeout.
        doReset();
        applyStimulus(8'h04, TIMEOUT_CYC, 2, 0);
        idleCycles(3, 0);
        applyStimulus(8'h04, 0, 2, 0);
        idleCycles(3, 0);

        // Request withdrawn during ARB: back to IDLE, no window.
        req_x = 8'h20;
        @(negedge clk);
        req_x = 8'h00;
        idleCycles(6, 0);

        // Randomized windows with stray done pulses and req churn in SEL.
        for (int t = 0; t < 60; t++) begin
            logic [7:0] r;
            r = 8'($urandom_range(1, 255));
            applyStimulus(r, $urandom_range(0, 18), 2, 1'($urandom % 2));
            idleCycles($urandom_range(2, 4), 1);
        end

`ifdef ROW_ENC_LOOPBACK_CHECK_EN
        checkOutput("loopbackClean", 32'(loopback_err), 0);
`endif

        // Reset in the middle of SEL: select drops at once, no grant.
        req_x = 8'h08;
        for (int c = 0; c < 10 && !select; c++) @(negedge clk);
        checkOutput("midSelRise", 32'(select), 1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midSelDrop", 32'(select), 0);
        checkOutput("midSelGrant", 32'(grant_x), 0);
        req_x = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 7;
        model_err = 0;
        idleCycles(3, 0);
        applyStimulus(8'h08, 2, 2, 0);
        idleCycles(3, 0);

`ifdef ROW_ENC_LOOPBACK_CHECK_EN
        // Decoder feeding back the wrong row while row 3 is selected.
        req_x = 8'h08;
        for (int c = 0; c < 10 && !select; c++) @(negedge clk);
        fb_value = 8'h02;
        fb_force = 1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("loopbackErr", 32'(loopback_err), 1);
        fb_force = 0;
        doReset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
